// File: rtl/sevenseg_scanner_if.sv
// Display-register side of the seven-segment scanner. The master drives the
// display value and controls; the slave (the scanner) drives the board pins.
interface sevenseg_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_out;
  logic                    frame_done;
  logic                    update_pending;

  modport master (
    output value, load, dp, digit_en, lz_suppress, blank,
    input  an, seg, dp_out, frame_done, update_pending
  );

  modport slave (
    input  value, load, dp, digit_en, lz_suppress, blank,
    output an, seg, dp_out, frame_done, update_pending
  );
endinterface

// File: rtl/sevenseg_scanner.sv
// Multiplexed N-digit seven-segment scanner with a double-buffered value,
// leading-zero blanking, per-digit enables, decimal points and a frame strobe.
module sevenseg_scanner #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  sevenseg_scanner_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    upd_q, upd_d;
  logic                    fd_q, fd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;

  logic                  tick, wrap, suppressed, lit, run;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;
      4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;
      default: glyph = 7'h47;
    endcase
  endfunction

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    wrap  = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? '0 : (tick ? idx_q + 1'b1 : idx_q);

    // disp only changes at a frame boundary so a frame never mixes values.
    pend_d = pend_q;
    disp_d = disp_q;
    upd_d  = upd_q;
    fd_d   = wrap;
    if (bus.load && wrap) begin
      pend_d = bus.value;
      disp_d = bus.value;
      upd_d  = 1'b0;
    end else begin
      if (wrap && upd_q) begin
        disp_d = pend_q;
        upd_d  = 1'b0;
      end
      if (bus.load) begin
        pend_d = bus.value;
        upd_d  = 1'b1;
      end
    end

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of disp are all zero.
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run && (disp_q[4*i +: 4] == 4'd0);
      upper_zero[i] = run;
    end

    nib        = disp_q[4*idx_q +: 4];
    suppressed = bus.lz_suppress && (idx_q != '0) && upper_zero[idx_q];
    lit        = !bus.blank && bus.digit_en[idx_q] && !suppressed;
    onehot     = NUM_DIGITS'(1) << idx_q;

    an_d  = lit ? (onehot ^ AN_OFF) : AN_OFF;
    seg_d = lit ? (glyph(nib) ^ SEG_OFF) : SEG_OFF;
    dpo_d = (lit && bus.dp[idx_q]) ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      upd_q  <= 1'b0;
      fd_q   <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dpo_q  <= SEG_ACTIVE_LOW;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      upd_q  <= upd_d;
      fd_q   <= fd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
    end
  end

  assign bus.an             = an_q;
  assign bus.seg            = seg_q;
  assign bus.dp_out         = dpo_q;
  assign bus.frame_done     = fd_q;
  assign bus.update_pending = upd_q;
endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner: 4 digits, 4 clocks per digit slot,
// active-low anodes and segments.
module tb_sevenseg_scanner;
  localparam int ND = 4;
  localparam int DV = 4;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0111000;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scanner #(
    .NUM_DIGITS    (ND),
    .DIV           (DV),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int e = 0;   // clock edges since the last reset release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, e, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic goto_edge(input int t);
    while (e < t) cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_an;
    logic [6:0] tab_seg [4];
    logic [3:0] tab_an  [4];
    logic       tab_dp  [4];
    int d;

    bus.value       = '0;
    bus.load        = 1'b0;
    bus.dp          = '0;
    bus.digit_en    = 4'b1111;
    bus.lz_suppress = 1'b0;
    bus.blank       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'(4'b1111));
    chk("rst_seg", 32'(bus.seg), 32'(SOFF));
    chk("rst_dp", 32'(bus.dp_out), 32'd1);
    chk("rst_fd", 32'(bus.frame_done), 32'd0);
    chk("rst_upd", 32'(bus.update_pending), 32'd0);
    rst_n = 1'b1;
    e = 0;

    // Two full frames of zeros: rotation, hold time, frame_done period
    for (int k = 1; k <= 32; k++) begin
      cyc(1);
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      chk("scan_an", 32'(bus.an), 32'(exp_an));
      chk("scan_seg", 32'(bus.seg), 32'(S0));
      chk("scan_fd", 32'(bus.frame_done), 32'((k % 16) == 0));
    end

    // Mid-frame load: held pending, no new glyph until after the wrap
    goto_edge(38);
    bus.value = 16'h12AF;
    bus.load  = 1'b1;
    cyc(1);
    bus.load  = 1'b0;
    while (e <= 48) begin
      chk("pend_upd", 32'(bus.update_pending), 32'(e < 48));
      chk("pend_seg", 32'(bus.seg), 32'(S0));
      chk("pend_fd", 32'(bus.frame_done), 32'(e == 48));
      cyc(1);
    end

    // New frame shows F A 2 1; load in the wrap cycle at the end
    tab_seg = '{SF, SA, S2, S1};
    while (e < 64) begin
      d = (e - 49) / 4;
      exp_an = ~(4'b0001 << d);
      chk("new_an", 32'(bus.an), 32'(exp_an));
      chk("new_seg", 32'(bus.seg), 32'(tab_seg[d]));
      if (e == 63) begin
        bus.value = 16'h0005;
        bus.load  = 1'b1;
      end
      cyc(1);
    end
    bus.load = 1'b0;
    chk("wrapload_upd", 32'(bus.update_pending), 32'd0);
    chk("wrapload_fd", 32'(bus.frame_done), 32'd1);
    chk("wrapload_old", 32'(bus.seg), 32'(S1));
    goto_edge(65);
    chk("five_an", 32'(bus.an), 32'(4'b1110));
    chk("five_seg", 32'(bus.seg), 32'(S5));
    goto_edge(69);
    chk("five_d1_an", 32'(bus.an), 32'(4'b1101));
    chk("five_d1_seg", 32'(bus.seg), 32'(S0));

    // Leading-zero suppression with 0050
    bus.lz_suppress = 1'b1;
    bus.value = 16'h0050;
    bus.load  = 1'b1;
    cyc(1);
    bus.load  = 1'b0;
    chk("lz_upd", 32'(bus.update_pending), 32'd1);
    goto_edge(81);
    chk("lz_d0_an", 32'(bus.an), 32'(4'b1110));
    chk("lz_d0_seg", 32'(bus.seg), 32'(S0));
    goto_edge(85);
    chk("lz_d1_an", 32'(bus.an), 32'(4'b1101));
    chk("lz_d1_seg", 32'(bus.seg), 32'(S5));
    goto_edge(89);
    chk("lz_d2_an", 32'(bus.an), 32'(4'b1111));
    chk("lz_d2_seg", 32'(bus.seg), 32'(SOFF));
    goto_edge(93);
    chk("lz_d3_an", 32'(bus.an), 32'(4'b1111));
    chk("lz_d3_dp", 32'(bus.dp_out), 32'd1);

    // All-zero value: only digit 0 lit
    bus.value = 16'h0000;
    bus.load  = 1'b1;
    cyc(1);
    bus.load  = 1'b0;
    goto_edge(97);
    chk("lz0_d0_an", 32'(bus.an), 32'(4'b1110));
    chk("lz0_d0_seg", 32'(bus.seg), 32'(S0));
    for (int k = 101; k <= 109; k += 4) begin
      goto_edge(k);
      chk("lz0_off_an", 32'(bus.an), 32'(4'b1111));
      chk("lz0_off_seg", 32'(bus.seg), 32'(SOFF));
    end

    // Digit enable mask and decimal point
    goto_edge(112);
    bus.lz_suppress = 1'b0;
    bus.digit_en    = 4'b1011;
    bus.dp          = 4'b0001;
    tab_an = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
    tab_dp = '{1'b0, 1'b1, 1'b1, 1'b1};
    tab_seg = '{S0, S0, SOFF, S0};
    goto_edge(113);
    while (e <= 128) begin
      d = (e - 113) / 4;
      chk("en_an", 32'(bus.an), 32'(tab_an[d]));
      chk("en_dp", 32'(bus.dp_out), 32'(tab_dp[d]));
      chk("en_seg", 32'(bus.seg), 32'(tab_seg[d]));
      cyc(1);
    end

    // One-cycle blank pulse during digit 0
    chk("blk_pre_an", 32'(bus.an), 32'(4'b1110));
    bus.blank = 1'b1;
    cyc(1);
    bus.blank = 1'b0;
    chk("blk_an", 32'(bus.an), 32'(4'b1111));
    chk("blk_seg", 32'(bus.seg), 32'(SOFF));
    chk("blk_dp", 32'(bus.dp_out), 32'd1);
    cyc(1);
    chk("blk_post_an", 32'(bus.an), 32'(4'b1110));
    chk("blk_post_dp", 32'(bus.dp_out), 32'd0);

    // Asynchronous reset with a pending value
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    cyc(1);
    bus.load  = 1'b0;
    chk("ar_pre_upd", 32'(bus.update_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_an", 32'(bus.an), 32'(4'b1111));
    chk("ar_seg", 32'(bus.seg), 32'(SOFF));
    chk("ar_dp", 32'(bus.dp_out), 32'd1);
    chk("ar_upd", 32'(bus.update_pending), 32'd0);
    chk("ar_fd", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    goto_edge(1);
    chk("ar_rel_an", 32'(bus.an), 32'(4'b1110));
    chk("ar_rel_seg", 32'(bus.seg), 32'(S0));
    chk("ar_rel_upd", 32'(bus.update_pending), 32'd0);
    goto_edge(16);
    chk("ar_fd_wrap", 32'(bus.frame_done), 32'd1);
    goto_edge(17);
    chk("ar_discard_seg", 32'(bus.seg), 32'(S0));
    chk("ar_discard_an", 32'(bus.an), 32'(4'b1110));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
